// File: rtl/rvfi_ser_pkg.sv
// rtl/rvfi_ser_pkg.sv - shared constants, entry type and popcount helper for the RVFI retire serializer
package rvfi_ser_pkg;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_ORDER    = 2'd2;

  localparam int MAX_NRET    = 4;
  localparam int DEF_PKT_W   = 512;
  localparam int DEF_ORDER_W = 64;

  typedef struct packed {
    logic [DEF_ORDER_W-1:0] order;
    logic [DEF_PKT_W-1:0]   pkt;
  } rvfi_entry_t;

  function automatic logic [2:0] popcount(input logic [MAX_NRET-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < MAX_NRET; i++) c = c + 3'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/rvfi_ser_fifo.sv
// rtl/rvfi_ser_fifo.sv - circular buffer taking up to NRET compacted writes and one read per cycle
module rvfi_ser_fifo
  import rvfi_ser_pkg::*;
#(
  parameter int NRET    = 2,
  parameter int PKT_W   = 512,
  parameter int ORDER_W = 64,
  parameter int DEPTH   = 16
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic [NRET-1:0]                i_wr_en,
  input  logic [NRET*$clog2(DEPTH)-1:0]  i_wr_idx,
  input  logic [$clog2(DEPTH):0]         i_wr_cnt,
  input  logic [NRET*ORDER_W-1:0]        i_wr_order,
  input  logic [NRET*PKT_W-1:0]          i_wr_pkt,
  input  logic                           i_rd,
  output logic                           o_valid,
  output logic [ORDER_W-1:0]             o_order,
  output logic [PKT_W-1:0]               o_pkt,
  output logic [$clog2(DEPTH):0]         o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [ORDER_W-1:0] r_mem_order [DEPTH];
  logic [PKT_W-1:0]   r_mem_pkt   [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_level;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + i_wr_cnt[AW-1:0];
      r_rd_ptr <= r_rd_ptr + AW'(i_rd);
      r_level  <= r_level + i_wr_cnt - (AW+1)'(i_rd);
    end
  end

  // Each enabled channel lands at its prefix offset, so the valid set packs densely.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NRET; k++) begin
      if (i_wr_en[k]) begin
        r_mem_order[r_wr_ptr + i_wr_idx[k*AW +: AW]] <= i_wr_order[k*ORDER_W +: ORDER_W];
        r_mem_pkt[r_wr_ptr + i_wr_idx[k*AW +: AW]]   <= i_wr_pkt[k*PKT_W +: PKT_W];
      end
    end
  end

  assign o_valid = (r_level != '0);
  assign o_order = r_mem_order[r_rd_ptr];
  assign o_pkt   = r_mem_pkt[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/rvfi_retire_serializer.sv
// rtl/rvfi_retire_serializer.sv - compacts multi-retire RVFI packets into one stream with order and overflow checks
module rvfi_retire_serializer
  import rvfi_ser_pkg::*;
#(
  parameter int NRET    = 2,
  parameter int PKT_W   = 512,
  parameter int ORDER_W = 64,
  parameter int DEPTH   = 16
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NRET-1:0]            in_valid,
  input  logic [NRET*ORDER_W-1:0]    in_order,
  input  logic [NRET*PKT_W-1:0]      in_pkt,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ORDER_W-1:0]         out_order,
  output logic [PKT_W-1:0]           out_pkt,
  output logic [$clog2(DEPTH):0]     level,
  output logic [1:0]                 errcode,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);

  logic [MAX_NRET-1:0]  w_valid4;
  logic [AW:0]          w_n;
  logic [AW:0]          w_free;
  logic                 w_overflow;
  logic [NRET*AW-1:0]   w_idx;
  logic [NRET-1:0]      w_wr_en;
  logic [AW:0]          w_wr_cnt;
  logic                 w_pop;
  logic                 w_gap;

  logic [1:0]           r_errcode;
  logic [ORDER_W-1:0]   r_exp_order;
  logic                 r_first_seen;

  always_comb begin
    w_valid4 = '0;
    w_valid4[NRET-1:0] = in_valid;
    w_n = (AW+1)'(popcount(w_valid4));
  end

  // Free space is taken before this cycle's pop, so a pop never rescues a push.
  assign w_free     = (AW+1)'(DEPTH) - level;
  assign w_overflow = (w_n > w_free);
  assign w_wr_en    = w_overflow ? '0 : in_valid;
  assign w_wr_cnt   = w_overflow ? '0 : w_n;
  assign in_ready   = (w_free >= (AW+1)'(NRET));

  always_comb begin
    logic [AW-1:0] v_cnt;
    v_cnt = '0;
    w_idx = '0;
    for (int k = 0; k < NRET; k++) begin
      w_idx[k*AW +: AW] = v_cnt;
      v_cnt = v_cnt + AW'(in_valid[k]);
    end
  end

  rvfi_ser_fifo #(
    .NRET    (NRET),
    .PKT_W   (PKT_W),
    .ORDER_W (ORDER_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_idx),
    .i_wr_cnt   (w_wr_cnt),
    .i_wr_order (in_order),
    .i_wr_pkt   (in_pkt),
    .i_rd       (w_pop),
    .o_valid    (out_valid),
    .o_order    (out_order),
    .o_pkt      (out_pkt),
    .o_level    (level)
  );

  assign w_pop = out_valid & out_ready;
  assign w_gap = w_pop & r_first_seen & (out_order != r_exp_order);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_errcode    <= ERR_NONE;
      r_exp_order  <= '0;
      r_first_seen <= 1'b0;
    end else begin
      r_errcode <= r_errcode | (w_overflow ? ERR_OVERFLOW : ERR_NONE) | (w_gap ? ERR_ORDER : ERR_NONE);
      if (w_pop) begin
        r_exp_order  <= out_order + ORDER_W'(1);
        r_first_seen <= 1'b1;
      end
    end
  end

  assign errcode = r_errcode;
  assign err     = |r_errcode;

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// tb/tb_rvfi_retire_serializer.sv - directed self-checking bench for rvfi_retire_serializer
module tb_rvfi_retire_serializer;

  localparam int NRET  = 2;
  localparam int PKT_W = 16;
  localparam int OW    = 8;
  localparam int DEPTH = 16;

  logic              clock = 1'b0;
  logic              resetn;
  logic [NRET-1:0]   in_valid;
  logic [NRET*OW-1:0] in_order;
  logic [NRET*PKT_W-1:0] in_pkt;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_order;
  logic [PKT_W-1:0]  out_pkt;
  logic [4:0]        level;
  logic [1:0]        errcode;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  rvfi_retire_serializer #(
    .NRET(NRET), .PKT_W(PKT_W), .ORDER_W(OW), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_order(in_order),
    .in_pkt(in_pkt), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_order(out_order), .out_pkt(out_pkt), .level(level), .errcode(errcode), .err(err)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Packet for a channel is {order, ~order} so payload routing is visible.
  task automatic drive(input logic [1:0] v, input logic [7:0] o0, input logic [7:0] o1);
    in_valid = v;
    in_order = {o1, o0};
    in_pkt   = {o1, ~o1, o0, ~o0};
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(2'b00, 8'd0, 8'd0);
    out_ready = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (errcode !== 2'd0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0d/%b want 0/0", errcode, err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(2'b01, 8'(i), 8'd0);
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_order !== 8'(i) || level !== 5'd1) begin
        n_bad++; $display("FAIL single_head[%0d] got v=%b o=%0d l=%0d want v=1 o=%0d l=1", i, out_valid, out_order, level, i);
      end
    end
    drive(2'b00, 8'd0, 8'd0);
    step();
    n_cmp++; if (level !== 5'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain got l=%0d v=%b want 0/0", level, out_valid); end
    n_cmp++; if (errcode !== 2'd0) begin n_bad++; $display("FAIL single_errcode got %0d want 0", errcode); end
  endtask

  task automatic test_dual_compaction();
    do_reset();
    out_ready = 1'b1;
    drive(2'b11, 8'd5, 8'd6);
    step();
    n_cmp++; if (level !== 5'd2 || out_order !== 8'd5 || out_pkt !== 16'h05FA) begin
      n_bad++; $display("FAIL dual_a got l=%0d o=%0d p=%h want l=2 o=5 p=05fa", level, out_order, out_pkt);
    end
    drive(2'b10, 8'd99, 8'd7);
    step();
    n_cmp++; if (level !== 5'd2 || out_order !== 8'd6) begin n_bad++; $display("FAIL dual_b got l=%0d o=%0d want l=2 o=6", level, out_order); end
    drive(2'b00, 8'd0, 8'd0);
    step();
    n_cmp++; if (level !== 5'd1 || out_order !== 8'd7 || out_pkt !== 16'h07F8) begin
      n_bad++; $display("FAIL dual_c got l=%0d o=%0d p=%h want l=1 o=7 p=07f8", level, out_order, out_pkt);
    end
    step();
    n_cmp++; if (level !== 5'd0 || errcode !== 2'd0) begin n_bad++; $display("FAIL dual_end got l=%0d e=%0d want 0/0", level, errcode); end
  endtask

  task automatic fill_full();
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(2'b11, 8'(2*c), 8'(2*c+1));
      step();
      if (c == 6) begin
        n_cmp++; if (level !== 5'd14 || in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_14 got l=%0d r=%b want 14/1", level, in_ready); end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fill_full();
    n_cmp++; if (level !== 5'd16 || in_ready !== 1'b0) begin n_bad++; $display("FAIL full got l=%0d r=%b want 16/0", level, in_ready); end
    n_cmp++; if (errcode !== 2'd0 || out_order !== 8'd0) begin n_bad++; $display("FAIL full_state got e=%0d o=%0d want 0/0", errcode, out_order); end
    drive(2'b01, 8'd16, 8'd0);
    out_ready = 1'b1;
    step();
    n_cmp++; if (level !== 5'd15 || errcode !== 2'd1 || err !== 1'b1) begin
      n_bad++; $display("FAIL overflow got l=%0d e=%0d err=%b want 15/1/1", level, errcode, err);
    end
    drive(2'b00, 8'd0, 8'd0);
    for (int d = 1; d <= 15; d++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_order !== 8'(d)) begin
        n_bad++; $display("FAIL ovf_drain[%0d] got v=%b o=%0d want v=1 o=%0d", d, out_valid, out_order, d);
      end
      step();
    end
    n_cmp++; if (level !== 5'd0 || errcode !== 2'd1) begin n_bad++; $display("FAIL ovf_end got l=%0d e=%0d want 0/1", level, errcode); end
  endtask

  task automatic test_order_gap();
    logic [7:0] ords [4];
    logic [1:0] exp_e [4];
    ords = '{8'd3, 8'd4, 8'd6, 8'd7};
    exp_e = '{2'd0, 2'd0, 2'd0, 2'd2};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, ords[i], 8'd0);
      step();
      n_cmp++; if (errcode !== exp_e[i] || out_order !== ords[i]) begin
        n_bad++; $display("FAIL gap[%0d] got e=%0d o=%0d want e=%0d o=%0d", i, errcode, out_order, exp_e[i], ords[i]);
      end
    end
    drive(2'b00, 8'd0, 8'd0);
    step();
    n_cmp++; if (errcode !== 2'd2 || level !== 5'd0) begin n_bad++; $display("FAIL gap_end got e=%0d l=%0d want 2/0", errcode, level); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      drive(2'b11, 8'(250 + 2*c), 8'(251 + 2*c));
      step();
      n_cmp++; if (level !== 5'(c + 2) || out_order !== 8'(250 + c)) begin
        n_bad++; $display("FAIL wrap_fill[%0d] got l=%0d o=%0d want l=%0d o=%0d", c, level, out_order, c + 2, 8'(250 + c));
      end
    end
    drive(2'b00, 8'd0, 8'd0);
    for (int d = 1; d <= 12; d++) begin
      step();
      if (d < 12) begin
        n_cmp++; if (out_order !== 8'(260 + d) || level !== 5'(12 - d)) begin
          n_bad++; $display("FAIL wrap_drain[%0d] got o=%0d l=%0d want o=%0d l=%0d", d, out_order, level, 8'(260 + d), 12 - d);
        end
      end
    end
    n_cmp++; if (level !== 5'd0 || errcode !== 2'd0) begin n_bad++; $display("FAIL wrap_end got l=%0d e=%0d want 0/0", level, errcode); end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    fill_full();
    drive(2'b01, 8'd16, 8'd0);
    step();
    drive(2'b00, 8'd0, 8'd0);
    out_ready = 1'b1;
    for (int d = 0; d < 11; d++) step();
    n_cmp++; if (level !== 5'd5 || errcode !== 2'd1) begin n_bad++; $display("FAIL mid_pre got l=%0d e=%0d want 5/1", level, errcode); end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    n_cmp++; if (level !== 5'd0 || out_valid !== 1'b0 || errcode !== 2'd0) begin
      n_bad++; $display("FAIL mid_reset got l=%0d v=%b e=%0d want 0/0/0", level, out_valid, errcode);
    end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_idle got v=%b want 0", out_valid); end
    drive(2'b01, 8'd100, 8'd0);
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_order !== 8'd100) begin n_bad++; $display("FAIL mid_first got v=%b o=%0d want 1/100", out_valid, out_order); end
    drive(2'b01, 8'd101, 8'd0);
    step();
    drive(2'b00, 8'd0, 8'd0);
    step();
    n_cmp++; if (errcode !== 2'd0 || level !== 5'd0) begin n_bad++; $display("FAIL mid_end got e=%0d l=%0d want 0/0", errcode, level); end
  endtask

  initial begin
    resetn = 1'b0;
    out_ready = 1'b0;
    drive(2'b00, 8'd0, 8'd0);
    test_reset();
    test_single_stream();
    test_dual_compaction();
    test_overflow();
    test_order_gap();
    test_wrap();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_serializer.md
Name: rvfi_retire_serializer

Overview:
- Sits between a multi-retire core's RVFI outputs and a single-channel consumer (checker, trace sink, RVFIMonitor-style error reporter).
- Accepts up to NRET retirement packets per cycle and compacts them in channel order into a FIFO.
- Emits exactly one packet per cycle under a valid/ready handshake.
- Checks global rvfi_order continuity and flags overflow, since the core cannot be stalled by RVFI.

Parameters:
- NRET, 2, retirement channels per cycle (1..4).
- PKT_W, 512, packed width of one RVFI packet excluding order.
- ORDER_W, 64, width of rvfi_order.
- DEPTH, 16, FIFO entries; power of two, >= 2*NRET.

Ports:
- clock  in  1  sole clock
- resetn  in  1  synchronous reset, active-low
- in_valid  in  NRET  per-channel retire valid (rvfi_valid)
- in_order  in  NRET*ORDER_W  per-channel rvfi_order, channel k at [k*ORDER_W +: ORDER_W]
- in_pkt  in  NRET*PKT_W  per-channel packed RVFI fields
- in_ready  out  1  advisory: free entries >= NRET
- out_valid  out  1  head entry present
- out_ready  in  1  consumer accepts head
- out_order  out  ORDER_W  head order
- out_pkt  out  PKT_W  head packet
- level  out  $clog2(DEPTH)+1  current occupancy
- errcode  out  2  sticky: 0 none, 1 overflow, 2 order gap, 3 both
- err  out  1  |errcode

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - On a clock edge with resetn=0: FIFO emptied (rd_ptr=wr_ptr=0, level=0), out_valid=0, errcode=0, expected_order=0, first_seen=0. in_ready resets to 1.
  - out_pkt and out_order are don't-care while out_valid=0.
  - Reset mid-stream discards all buffered packets; nothing is emitted after reset until new input arrives.
- Push:
  - Let n = popcount(in_valid).
  - When n <= free (free = DEPTH - level), the valid channels are written in ascending channel index to wr_ptr, wr_ptr+1, …, and wr_ptr advances by n.
  - Pointers wrap modulo DEPTH.
  - Invalid channels leave no gap (compaction). Example: in_valid=2'b10 writes channel 1 at wr_ptr.
- Overflow:
  - When n > free, the whole cycle's packets are dropped (no partial write) and errcode[0] is set.
  - Free is evaluated before that cycle's pop, so a simultaneous pop does not rescue the push. This rule is decided and keeps timing simple.
- Pop:
  - out_valid = (level != 0), driven from registered state; in-to-out latency is 1 cycle minimum.
  - Handshake: when out_valid && out_ready, rd_ptr advances by 1.
  - out_pkt and out_order must hold stable while out_valid && !out_ready.
- Simultaneous events: push and pop in the same cycle give level_next = level + n - pop.
  - Full with pop and n=1 still overflows (free=0 pre-pop).
  - Empty with push: no same-cycle bypass; out_valid rises the next cycle.
- Order check, performed on each output handshake:
  - First handshake after reset: expected_order <= out_order + 1, first_seen <= 1, no check.
  - Later handshakes: if out_order != expected_order, set errcode[1]; in all cases expected_order <= out_order + 1, wrapping modulo 2^ORDER_W with no error at the wrap.
  - Within one input cycle, channel k must carry order lower than channel k+1. This is not checked at input; a violation surfaces as a gap at output.
- Error flags: errcode bits are sticky until reset; packets continue to flow after an error.
- level is registered and equals occupancy after the last edge.

Decomposition:
- Package rvfi_ser_pkg:
  - ERR_NONE=2'd0, ERR_OVERFLOW=2'd1, ERR_ORDER=2'd2 constants.
  - Helper function popcount over NRET.
  - Typedef for the {order, pkt} entry struct.
- Sub-module rvfi_ser_fifo: multi-write (up to NRET, compacted), single-read circular buffer with pointers and level.
- Top level holds:
  - channel compaction index logic (prefix popcount per channel);
  - overflow decision;
  - order checker;
  - error registers.

Test Plan:
- Reset, then single-channel stream: in_valid=01, orders 0..9 one per cycle, out_ready=1 → out_order 0..9 on consecutive cycles starting 1 cycle after first push; errcode=0.
- Dual retire with compaction: cycle A in_valid=11 orders {5,6}, cycle B in_valid=10 order 7 → outputs 5,6,7 in order; level peaks at 2.
- Backpressure to full and overflow (DEPTH=16, out_ready=0):
  - push 8 cycles of in_valid=11 → level=16, in_ready=0;
  - next in_valid=01 with out_ready=1 → packet dropped, errcode=1, level=15 after the edge.
- Order gap: push orders 3,4,6 → errcode becomes 2 on the handshake of order 6; stream continues; a subsequent 7 raises no further change.
- Wrap: ORDER_W=4, orders 14,15,0,1 → errcode stays 0; pointer wrap exercised with 20+ entries passing through a DEPTH=16 FIFO.
- Mid-stream reset: level=5 and errcode=1, assert resetn=0 for one cycle → level=0, out_valid=0, errcode=0; next input order 100 is accepted as first with no gap error.
